// File: rtl/mdu_ctrl_if.sv
// E-stage MDU request/response bundle shared by the pipeline and the MDU sequencer.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        D_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  start, op, rs_val, rt_val, D_md,
    output busy, stall_req, result, hi, lo
  );

  modport master (
    output start, op, rs_val, rt_val, D_md,
    input  busy, stall_req, result, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: computes the result at issue and commits it to HI/LO
// after a fixed latency, stalling D-stage MDU instructions while an op is in flight.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy, div_zero;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign busy     = (cnt_q != 4'd0);
  assign div_zero = (bus.rt_val == 32'd0);

  // Sign-extend to 64 bits so the low 64 bits of the product are the exact signed result.
  assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                  $signed({{32{bus.rt_val[31]}}, bus.rt_val});
  assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
  assign quo_s  = $signed(bus.rs_val) / $signed(bus.rt_val);
  assign rem_s  = $signed(bus.rs_val) % $signed(bus.rt_val);
  assign quo_u  = bus.rs_val / bus.rt_val;
  assign rem_u  = bus.rs_val % bus.rt_val;

  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy) begin
      // Any start seen here is a protocol violation and is dropped.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (bus.start) begin
      case (bus.op)
        OP_MULT: begin
          cnt_d                  = 4'(MUL_LAT);
          {pend_hi_d, pend_lo_d} = prod_s;
        end
        OP_MULTU: begin
          cnt_d                  = 4'(MUL_LAT);
          {pend_hi_d, pend_lo_d} = prod_u;
        end
        OP_DIV: begin
          cnt_d     = 4'(DIV_LAT);
          pend_hi_d = div_zero ? hi_q : rem_s;
          pend_lo_d = div_zero ? lo_q : quo_s;
        end
        OP_DIVU: begin
          cnt_d     = 4'(DIV_LAT);
          pend_hi_d = div_zero ? hi_q : rem_u;
          pend_lo_d = div_zero ? lo_q : quo_u;
        end
        OP_MTHI: hi_d = bus.rs_val;
        OP_MTLO: lo_d = bus.rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.stall_req = bus.D_md & (busy | (bus.start & ~bus.op[2]));
  assign bus.result    = (bus.op == OP_MFHI) ? hi_q :
                         (bus.op == OP_MFLO) ? lo_q : 32'd0;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboarded bench for mdu_ctrl: stimulus queues expected HI/LO commits and MF reads,
// a monitor compares them when the DUT commits or serves a read.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if bus();
  mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] hi; logic [31:0] lo; string nm; } commit_t;
  typedef struct { logic [31:0] v; string nm; } rd_t;
  commit_t commit_q[$];
  rd_t     rd_q[$];
  int ntests = 0;
  int nfail  = 0;
  int nviol  = 0;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Commit monitor: busy falling without a reset in between means HI/LO just updated.
  initial begin
    logic pb, pr;
    commit_t c;
    rd_t r;
    pb = 1'b0; pr = 1'b1;
    forever begin
      @(negedge clk);
      if (pb && !bus.busy && !pr) begin
        if (commit_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_commit: hi=%h lo=%h", bus.hi, bus.lo);
        end else begin
          c = commit_q.pop_front();
          chk(bus.hi, c.hi, {c.nm, "_hi"});
          chk(bus.lo, c.lo, {c.nm, "_lo"});
        end
      end
      if (bus.start && bus.op >= 3'd6 && !reset) begin
        if (rd_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_read: result=%h", bus.result);
        end else begin
          r = rd_q.pop_front();
          chk(bus.result, r.v, r.nm);
        end
      end
      if (bus.start && bus.busy && !reset) begin
        nviol++;
        $display("[TB] protocol note: start asserted while busy (ignored by DUT)");
      end
      pb = bus.busy;
      pr = reset;
    end
  end

  // Issue a mul/div, check stall/busy across the latency; viol_cyc>0 injects an MTHI then.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el,
                        input string nm, input int viol_cyc);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.D_md = 1'b1;
    commit_q.push_back('{eh, el, nm});
    @(negedge clk);
    chk(32'(bus.stall_req), 32'd1, {nm, "_stall_issue"});
    chk(32'(bus.busy), 32'd0, {nm, "_busy_issue"});
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (i == viol_cyc) begin
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'hBAD0BAD0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk(32'(bus.busy), 32'd1, {nm, "_busy"});
      chk(32'(bus.stall_req), 32'd1, {nm, "_stall_busy"});
      tick();
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk(32'(bus.busy), 32'd0, {nm, "_busy_done"});
    chk(32'(bus.stall_req), 32'd0, {nm, "_stall_done"});
    tick();
    bus.D_md = 1'b0;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    bus.start = 1'b1; bus.op = o; bus.rs_val = v;
    @(negedge clk);
    chk(32'(bus.busy), 32'd0, "mt_busy");
    tick();
    bus.start = 1'b0;
  endtask

  task automatic mf(input logic [2:0] o, input logic [31:0] v, input string nm);
    rd_q.push_back('{v, nm});
    bus.start = 1'b1; bus.op = o;
    @(negedge clk);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0; bus.D_md = 1'b1;
    @(negedge clk);
    chk(32'(bus.busy), 32'd0, "rst_busy");
    chk(bus.hi, 32'd0, "rst_hi");
    chk(bus.lo, 32'd0, "rst_lo");
    chk(bus.result, 32'd0, "rst_result");
    chk(32'(bus.stall_req), 32'd1, "rst_stall_comb");
    tick();
    @(negedge clk);
    chk(32'(bus.busy), 32'd0, "rst_busy2");
    tick();
    reset = 1'b0; bus.start = 1'b0; bus.D_md = 1'b0;

    run_md(3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult", 0);
    run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, "multu", 0);
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div", 0);
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC, "divu", 0);

    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    @(negedge clk);
    chk(bus.hi, 32'h11, "mthi_val");
    chk(bus.lo, 32'h22, "mtlo_val");
    tick();
    run_md(3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22, "div0", 0);
    mf(3'd7, 32'h22, "mflo_div0");
    mf(3'd6, 32'h11, "mfhi_div0");

    run_md(3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42, "mult_viol", 2);
    @(negedge clk);
    chk(bus.hi, 32'd0, "viol_hi_kept");
    chk(32'(nviol), 32'd1, "viol_flagged");
    tick();

    bus.start = 1'b1; bus.op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk(32'(bus.busy), 32'd1, "rdiv_busy");
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    chk(32'(bus.busy), 32'd1, "rdiv_busy_c3");
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk(32'(bus.busy), 32'd0, "rdiv_busy_after");
    chk(bus.hi, 32'd0, "rdiv_hi_after");
    chk(bus.lo, 32'd0, "rdiv_lo_after");
    repeat (12) tick();
    @(negedge clk);
    chk(32'(bus.busy), 32'd0, "rdiv_busy_late");
    chk(bus.hi, 32'd0, "rdiv_hi_late");
    chk(bus.lo, 32'd0, "rdiv_lo_late");
    tick();

    mt(3'd5, 32'hDEADBEEF);
    mf(3'd7, 32'hDEADBEEF, "mflo_bypass");
    bus.D_md = 1'b1; bus.start = 1'b0; bus.op = 3'd2;
    @(negedge clk);
    chk(32'(bus.stall_req), 32'd0, "stall_idle");
    chk(bus.result, 32'd0, "result_nonmf");
    tick();
    bus.D_md = 1'b0;
    repeat (2) tick();

    chk(32'(commit_q.size()), 32'd0, "commit_q_drained");
    chk(32'(rd_q.size()), 32'd0, "rd_q_drained");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the five-stage pipeline. It accepts MDU operations from the E stage, computes the 64-bit product or quotient/remainder, and holds the result pending for a fixed latency that models a multi-cycle unit. It commits the result to the architectural HI/LO registers when that latency expires, and raises a stall request to the hazard unit whenever a D-stage MDU instruction would collide with an operation in flight. MFHI/MFLO read data is returned combinationally, so the E/M pipeline register captures it as the E-stage MDU result.

## Interface
- MUL_LAT, 5, busy cycles for MULT/MULTU (1..15)
- DIV_LAT, 10, busy cycles for DIV/DIVU (1..15)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  valid MDU operation in E stage this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- D_md  in  1  D-stage instruction is any MDU op (including MF/MT)
- busy  out  1  operation in flight
- stall_req  out  1  freeze F/D, bubble E
- result  out  32  MFHI/MFLO read data
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Internal state: 4-bit down-counter cnt, pending registers pend_hi and pend_lo, and registers hi and lo. busy = (cnt != 0).
- Multiply or divide op accepted (start=1, op<=3, busy=0):
  - At the clock edge, cnt loads the latency: MUL_LAT for MULT/MULTU, DIV_LAT for DIV/DIVU.
  - pend_hi:pend_lo load the full result.
  - MULT: signed 64-bit product, upper half to HI, lower half to LO. MULTU: unsigned product, same split.
  - DIV: LO gets the signed quotient, truncated toward zero. HI gets the remainder, which carries the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - rt_val == 0 on DIV/DIVU: pend_hi/pend_lo load the current hi/lo. Full latency still runs; HI/LO are effectively unchanged.
- While cnt>0: cnt decrements each edge. On the edge where cnt==1, hi<=pend_hi and lo<=pend_lo.
- MTHI/MTLO (start=1, busy=0): hi (or lo) <= rs_val at the edge. No busy.
- MFHI/MFLO: result = hi (op 6) or lo (op 7). For any other op, result = 0. No state change.
- start=1 while busy=1: ignored entirely, with no state change. This is a protocol violation, because stall_req prevents it; the bench flags it.
- stall_req = D_md & (busy | (start & op<=3)). This covers the issue cycle and every busy cycle.
- reset: cnt, pend_hi, pend_lo, hi and lo all go to 0. An in-flight operation is discarded and never commits.

## Timing
- Reset values: busy=0, stall_req=D_md&start&(op<=3) (combinational), result=0, hi=0, lo=0.
- Multiply/divide issued in cycle t:
  - busy=1 in cycles t+1 .. t+LAT.
  - New HI/LO are visible from cycle t+LAT+1.
  - busy=0 in cycle t+LAT+1.
- Back-to-back issue: a new op may issue in cycle t+LAT+1 at the earliest.
- MTHI/MTLO in cycle t: the new value is visible in cycle t+1.
- MFHI in cycle t+1 after an MTHI in cycle t returns the new value. There is no internal bypass within the same cycle.
- result, busy and stall_req are combinational from registers and inputs.
- LAT of 1: busy for exactly one cycle.
- reset asserted in any busy cycle: busy=0 and hi=lo=0 in the following cycle.

## Test plan
- Reset, then MULT with rs=0xFFFFFFFE (-2) and rt=3 in cycle 0:
  - busy=1 in cycles 1-5.
  - hi=0xFFFFFFFF and lo=0xFFFFFFFA from cycle 6.
  - D_md=1 in cycles 0-5 gives stall_req=1; stall_req=0 in cycle 6.
- MULTU with rs=rt=0xFFFFFFFF gives hi=0xFFFFFFFE and lo=0x00000001 after 5 busy cycles.
- DIV with rs=-7 (0xFFFFFFF9) and rt=2:
  - busy for 10 cycles.
  - lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1).
  - DIVU with the same operands gives lo=0x7FFFFFFC and hi=1.
- DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO:
  - busy runs 10 cycles.
  - hi=0x11 and lo=0x22 unchanged.
  - MFLO afterwards gives result=0x22.
- Issue MULT, then assert start with MTHI in busy cycle 2: ignored, and hi equals the product after commit. Then assert reset in busy cycle 3 of a new DIV: busy=0, hi=lo=0 next cycle, and the pending result never appears.
- MTLO 0xDEADBEEF in cycle 0 and MFLO in cycle 1 gives result=0xDEADBEEF. D_md=1 with no MDU activity gives stall_req=0.
